// File: rtl/mac_vec_feeder.sv
// mac_vec_feeder: buffers one job (weights, vector, biases) from a byte
// stream, then streams VEC_S beats to a row of NUM_R parallel MAC lanes.
// Ports:
//   clk, reset        clock, async active-high reset
//   in_valid/in_ready load-stream handshake, in_data 8-bit load word
//   keep_weights      sampled with a job's first word: reuse stored weights
//   a_out             lane k weight at [8k+7:8k]
//   b_out             shared vector element
//   x_out             bias for lane j on beat j, else 0
//   valid_out         beat valid, done one-cycle end pulse, busy not IDLE
module mac_vec_feeder #(
    parameter int VEC_S = 4,
    parameter int NUM_R = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               keep_weights,
    output logic [NUM_R*8-1:0] a_out,
    output logic [7:0]         b_out,
    output logic [7:0]         x_out,
    output logic               valid_out,
    output logic               done,
    output logic               busy
);

    localparam int NW = NUM_R * VEC_S;
    localparam int CW = $clog2(NW + 1);

    localparam logic [CW-1:0] W_LAST = CW'(NW - 1);
    localparam logic [CW-1:0] V_LAST = CW'(VEC_S - 1);
    localparam logic [CW-1:0] X_LAST = CW'(NUM_R - 1);

    if (NUM_R > VEC_S) begin : g_bad_params
        $error("mac_vec_feeder: NUM_R must not exceed VEC_S");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_V,
        S_LOAD_X,
        S_STREAM,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_wts_ok;
    logic [7:0]         r_w [NW];
    logic [7:0]         r_v [VEC_S];
    logic [7:0]         r_x [NUM_R];
    logic [NUM_R*8-1:0] r_a;
    logic [7:0]         r_b;
    logic [7:0]         r_xo;
    logic               r_valid;
    logic               r_done;

    logic               w_acc;
    logic [CW-1:0]      w_beat;
    logic [NUM_R*8-1:0] w_a;
    logic [7:0]         w_b;
    logic [7:0]         w_xb;

    assign in_ready  = (r_state == S_IDLE)   || (r_state == S_LOAD_W) ||
                       (r_state == S_LOAD_V) || (r_state == S_LOAD_X);
    assign busy      = (r_state != S_IDLE);
    assign w_acc     = in_valid & in_ready;
    assign a_out     = r_a;
    assign b_out     = r_b;
    assign x_out     = r_xo;
    assign valid_out = r_valid;
    assign done      = r_done;

    // Beat 0 is registered on the edge that accepts the last bias, so the
    // beat being prepared is always one ahead of the counter in STREAM.
    assign w_beat = (r_state == S_STREAM) ? r_cnt + 1'b1 : '0;

    always_comb begin
        w_a  = '0;
        w_b  = '0;
        w_xb = '0;
        for (int c = 0; c < VEC_S; c++) begin
            if (w_beat == CW'(c)) begin
                for (int k = 0; k < NUM_R; k++) begin
                    w_a[k*8 +: 8] = r_w[k*VEC_S + c];
                end
                w_b = r_v[c];
            end
        end
        for (int j = 0; j < NUM_R; j++) begin
            if (w_beat == CW'(j)) begin
                w_xb = r_x[j];
            end
        end
        // With a single lane, X[0] is the word arriving on this very edge.
        if (NUM_R == 1 && r_state == S_LOAD_X) begin
            w_xb = in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_wts_ok <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_xo     <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            for (int i = 0; i < NW; i++) r_w[i] <= '0;
            for (int i = 0; i < VEC_S; i++) r_v[i] <= '0;
            for (int i = 0; i < NUM_R; i++) r_x[i] <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        if (keep_weights && r_wts_ok) begin
                            r_v[0] <= in_data;
                            if (VEC_S == 1) begin
                                r_state <= S_LOAD_X;
                                r_cnt   <= '0;
                            end else begin
                                r_state <= S_LOAD_V;
                                r_cnt   <= CW'(1);
                            end
                        end else begin
                            r_w[0] <= in_data;
                            if (NW == 1) begin
                                r_wts_ok <= 1'b1;
                                r_state  <= S_LOAD_V;
                                r_cnt    <= '0;
                            end else begin
                                r_state <= S_LOAD_W;
                                r_cnt   <= CW'(1);
                            end
                        end
                    end
                end
                S_LOAD_W: begin
                    if (w_acc) begin
                        for (int i = 0; i < NW; i++) begin
                            if (r_cnt == CW'(i)) r_w[i] <= in_data;
                        end
                        if (r_cnt == W_LAST) begin
                            r_wts_ok <= 1'b1;
                            r_state  <= S_LOAD_V;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_LOAD_V: begin
                    if (w_acc) begin
                        for (int i = 0; i < VEC_S; i++) begin
                            if (r_cnt == CW'(i)) r_v[i] <= in_data;
                        end
                        if (r_cnt == V_LAST) begin
                            r_state <= S_LOAD_X;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_LOAD_X: begin
                    if (w_acc) begin
                        for (int i = 0; i < NUM_R; i++) begin
                            if (r_cnt == CW'(i)) r_x[i] <= in_data;
                        end
                        if (r_cnt == X_LAST) begin
                            r_state <= S_STREAM;
                            r_cnt   <= '0;
                            r_a     <= w_a;
                            r_b     <= w_b;
                            r_xo    <= w_xb;
                            r_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (r_cnt == V_LAST) begin
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        r_a   <= w_a;
                        r_b   <= w_b;
                        r_xo  <= w_xb;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_vec_feeder.sv
// tb_mac_vec_feeder: scoreboard bench for mac_vec_feeder.
// Default instance plus a VEC_S=6 instance.
module tb_mac_vec_feeder;

    localparam int VS  = 4;
    localparam int NR  = 4;
    localparam int NW  = VS * NR;
    localparam int VS2 = 6;
    localparam int NR2 = 4;
    localparam int NW2 = VS2 * NR2;

    typedef struct packed {
        logic [NR*8-1:0] a;
        logic [7:0]      b;
        logic [7:0]      x;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic [7:0]      in_data = '0;
    logic            keep_weights = 1'b0;
    logic            in_ready;
    logic [NR*8-1:0] a_out;
    logic [7:0]      b_out;
    logic [7:0]      x_out;
    logic            valid_out;
    logic            done;
    logic            busy;

    logic             reset2 = 1'b1;
    logic             in_valid2 = 1'b0;
    logic [7:0]       in_data2 = '0;
    logic             keep2 = 1'b0;
    logic             in_ready2;
    logic [NR2*8-1:0] a_out2;
    logic [7:0]       b_out2;
    logic [7:0]       x_out2;
    logic             valid_out2;
    logic             done2;
    logic             busy2;

    mac_vec_feeder #(.VEC_S(VS), .NUM_R(NR)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .keep_weights(keep_weights), .a_out(a_out),
        .b_out(b_out), .x_out(x_out), .valid_out(valid_out), .done(done),
        .busy(busy)
    );

    mac_vec_feeder #(.VEC_S(VS2), .NUM_R(NR2)) u_dut6 (
        .clk(clk), .reset(reset2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .keep_weights(keep2), .a_out(a_out2),
        .b_out(b_out2), .x_out(x_out2), .valid_out(valid_out2), .done(done2),
        .busy(busy2)
    );

    int errs = 0;
    int checks = 0;

    logic [7:0] mw [NW];
    logic [7:0] mv [VS];
    logic [7:0] mx [NR];
    bit         m_ok = 1'b0;

    logic [7:0] jw [NW];
    logic [7:0] jv [VS];
    logic [7:0] jx [NR];

    beat_t exp_q [$];
    beat_t got_q [$];

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        m_ok = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push_expected();
        beat_t e;
        for (int j = 0; j < VS; j++) begin
            for (int k = 0; k < NR; k++) e.a[k*8 +: 8] = mw[k*VS + j];
            e.b = mv[j];
            e.x = (j < NR) ? mx[j] : 8'd0;
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input logic [7:0] d, input bit kw, input bit tog,
                        inout bit tmo);
        int n;
        bit ok;
        if (tog) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        n = 0;
        ok = 1'b0;
        while (!ok && n < 8) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = d;
            keep_weights = kw;
            ok = in_ready;
            @(posedge clk);
            n++;
        end
        if (!ok) tmo = 1'b1;
    endtask

    task automatic load_job(input bit kw, input bit tog, output bit tmo);
        logic [7:0] q [$];
        bit full;
        full = !(kw && m_ok);
        if (full) begin
            for (int i = 0; i < NW; i++) begin
                q.push_back(jw[i]);
                mw[i] = jw[i];
            end
            m_ok = 1'b1;
        end
        for (int i = 0; i < VS; i++) begin
            q.push_back(jv[i]);
            mv[i] = jv[i];
        end
        for (int i = 0; i < NR; i++) begin
            q.push_back(jx[i]);
            mx[i] = jx[i];
        end
        push_expected();
        tmo = 1'b0;
        foreach (q[i]) begin
            if (!tmo) send(q[i], (i == 0) ? kw : 1'($urandom), tog, tmo);
        end
    endtask

    task automatic collect(input bit hold, output int lat, output int nb,
                           output bit done_ok, output bit rdy, output bit tmo);
        got_q.delete();
        nb = 0;
        rdy = 1'b0;
        done_ok = 1'b1;
        tmo = 1'b0;
        @(negedge clk);
        in_valid = hold;
        lat = 1;
        while (!valid_out && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!valid_out) begin
            tmo = 1'b1;
            done_ok = 1'b0;
        end else begin
            while (valid_out && nb < 20) begin
                got_q.push_back('{a_out, b_out, x_out});
                if (in_ready) rdy = 1'b1;
                if (done) done_ok = 1'b0;
                nb++;
                @(negedge clk);
            end
            if (in_ready) rdy = 1'b1;
            if (!done) done_ok = 1'b0;
            @(negedge clk);
            in_valid = 1'b0;
            if (done) done_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        checks += 7;
        if (valid_out !== 1'b0) begin
            errs++; $display("FAIL reset_valid got=%b exp=0", valid_out);
        end
        if (done !== 1'b0) begin
            errs++; $display("FAIL reset_done got=%b exp=0", done);
        end
        if (busy !== 1'b0) begin
            errs++; $display("FAIL reset_busy got=%b exp=0", busy);
        end
        if (in_ready !== 1'b1) begin
            errs++; $display("FAIL reset_ready got=%b exp=1", in_ready);
        end
        if (a_out !== '0) begin
            errs++; $display("FAIL reset_a got=%h exp=0", a_out);
        end
        if (b_out !== 8'd0) begin
            errs++; $display("FAIL reset_b got=%h exp=0", b_out);
        end
        if (x_out !== 8'd0) begin
            errs++; $display("FAIL reset_x got=%h exp=0", x_out);
        end
    endtask

    task automatic set_job1();
        for (int i = 0; i < NW; i++) jw[i] = 8'(i + 1);
        for (int i = 0; i < VS; i++) jv[i] = 8'(i + 1);
        for (int i = 0; i < NR; i++) jx[i] = 8'(10 * (i + 1));
    endtask

    task automatic test_full_job();
        bit tmo, dok, rdy, ctmo;
        int lat, nb;
        beat_t e, g;
        set_job1();
        load_job(1'b0, 1'b0, tmo);
        collect(1'b0, lat, nb, dok, rdy, ctmo);
        checks += 5;
        if (tmo || ctmo) begin
            errs++; $display("FAIL full_timeout got=%b/%b exp=0/0", tmo, ctmo);
        end
        if (lat !== 1) begin
            errs++; $display("FAIL full_latency got=%0d exp=1", lat);
        end
        if (nb !== VS) begin
            errs++; $display("FAIL full_beats got=%0d exp=%0d", nb, VS);
        end
        if (!dok) begin
            errs++; $display("FAIL full_done got=0 exp=1");
        end
        if (rdy) begin
            errs++; $display("FAIL full_ready_stream got=1 exp=0");
        end
        if (got_q.size() == VS) begin
            checks += 2;
            if (got_q[0].a !== 32'h0D09_0501) begin
                errs++; $display("FAIL full_beat0_a got=%h exp=0d090501", got_q[0].a);
            end
            if (got_q[3].x !== 8'd40) begin
                errs++; $display("FAIL full_beat3_x got=%0d exp=40", got_q[3].x);
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            checks++;
            if (g !== e) begin
                errs++; $display("FAIL full_beat got=%h exp=%h", g, e);
            end
        end
    endtask

    task automatic test_keep_weights();
        bit tmo, dok, rdy, ctmo;
        int lat, nb;
        beat_t e, g;
        for (int i = 0; i < VS; i++) jv[i] = 8'hFF;
        for (int i = 0; i < NR; i++) jx[i] = 8'h00;
        load_job(1'b1, 1'b0, tmo);
        collect(1'b0, lat, nb, dok, rdy, ctmo);
        checks += 4;
        if (tmo || ctmo) begin
            errs++; $display("FAIL keep_timeout got=%b/%b exp=0/0", tmo, ctmo);
        end
        if (lat !== 1) begin
            errs++; $display("FAIL keep_latency got=%0d exp=1", lat);
        end
        if (nb !== VS) begin
            errs++; $display("FAIL keep_beats got=%0d exp=%0d", nb, VS);
        end
        if (!dok) begin
            errs++; $display("FAIL keep_done got=0 exp=1");
        end
        if (got_q.size() > 0) begin
            checks++;
            if (got_q[0].b !== 8'hFF) begin
                errs++; $display("FAIL keep_b got=%h exp=ff", got_q[0].b);
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            checks++;
            if (g !== e) begin
                errs++; $display("FAIL keep_beat got=%h exp=%h", g, e);
            end
        end
    endtask

    task automatic test_keep_after_reset();
        bit tmo, dok, rdy, ctmo;
        int lat, nb;
        beat_t e, g;
        do_reset();
        for (int i = 0; i < NW; i++) jw[i] = 8'(8'd200 - 8'(i * 7));
        for (int i = 0; i < VS; i++) jv[i] = 8'(8'h80 + 8'(i));
        for (int i = 0; i < NR; i++) jx[i] = 8'(8'd250 - 8'(i));
        load_job(1'b1, 1'b0, tmo);
        collect(1'b0, lat, nb, dok, rdy, ctmo);
        checks += 3;
        if (tmo || ctmo) begin
            errs++; $display("FAIL kar_timeout got=%b/%b exp=0/0", tmo, ctmo);
        end
        if (lat !== 1) begin
            errs++; $display("FAIL kar_latency got=%0d exp=1", lat);
        end
        if (nb !== VS) begin
            errs++; $display("FAIL kar_beats got=%0d exp=%0d", nb, VS);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            checks++;
            if (g !== e) begin
                errs++; $display("FAIL kar_beat got=%h exp=%h", g, e);
            end
        end
    endtask

    task automatic test_toggle();
        bit tmo, dok, rdy, ctmo;
        int lat, nb;
        beat_t e, g;
        set_job1();
        load_job(1'b0, 1'b1, tmo);
        collect(1'b1, lat, nb, dok, rdy, ctmo);
        checks += 5;
        if (tmo || ctmo) begin
            errs++; $display("FAIL tog_timeout got=%b/%b exp=0/0", tmo, ctmo);
        end
        if (lat !== 1) begin
            errs++; $display("FAIL tog_latency got=%0d exp=1", lat);
        end
        if (nb !== VS) begin
            errs++; $display("FAIL tog_beats got=%0d exp=%0d", nb, VS);
        end
        if (!dok) begin
            errs++; $display("FAIL tog_done got=0 exp=1");
        end
        if (rdy) begin
            errs++; $display("FAIL tog_ready_stream got=1 exp=0");
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            checks++;
            if (g !== e) begin
                errs++; $display("FAIL tog_beat got=%h exp=%h", g, e);
            end
        end
    endtask

    task automatic test_vec6();
        logic [7:0] w2 [NW2];
        logic [7:0] v2 [VS2];
        logic [7:0] x2 [NR2];
        logic [7:0] q [$];
        beat_t e2 [$];
        beat_t e, g;
        beat_t g2 [$];
        bit ok, tmo;
        int n, nv;
        for (int i = 0; i < NW2; i++) begin
            w2[i] = 8'($urandom);
            q.push_back(w2[i]);
        end
        for (int i = 0; i < VS2; i++) begin
            v2[i] = 8'($urandom);
            q.push_back(v2[i]);
        end
        for (int i = 0; i < NR2; i++) begin
            x2[i] = 8'($urandom_range(1, 255));
            q.push_back(x2[i]);
        end
        for (int j = 0; j < VS2; j++) begin
            for (int k = 0; k < NR2; k++) e.a[k*8 +: 8] = w2[k*VS2 + j];
            e.b = v2[j];
            e.x = (j < NR2) ? x2[j] : 8'd0;
            e2.push_back(e);
        end
        @(negedge clk);
        reset2 = 1'b0;
        tmo = 1'b0;
        foreach (q[i]) begin
            n = 0;
            ok = 1'b0;
            while (!tmo && !ok && n < 8) begin
                @(negedge clk);
                in_valid2 = 1'b1;
                in_data2 = q[i];
                ok = in_ready2;
                @(posedge clk);
                n++;
            end
            if (!ok) tmo = 1'b1;
        end
        @(negedge clk);
        in_valid2 = 1'b0;
        nv = 0;
        while (valid_out2 && nv < 20) begin
            g2.push_back('{a_out2, b_out2, x_out2});
            nv++;
            @(negedge clk);
        end
        checks += 3;
        if (tmo) begin
            errs++; $display("FAIL v6_timeout got=1 exp=0");
        end
        if (nv !== VS2) begin
            errs++; $display("FAIL v6_valid_cycles got=%0d exp=%0d", nv, VS2);
        end
        if (done2 !== 1'b1) begin
            errs++; $display("FAIL v6_done got=%b exp=1", done2);
        end
        if (g2.size() == VS2) begin
            checks += 2;
            if (g2[4].x !== 8'd0) begin
                errs++; $display("FAIL v6_beat4_x got=%h exp=0", g2[4].x);
            end
            if (g2[5].x !== 8'd0) begin
                errs++; $display("FAIL v6_beat5_x got=%h exp=0", g2[5].x);
            end
        end
        while (e2.size() > 0) begin
            e = e2.pop_front();
            g = (g2.size() > 0) ? g2.pop_front() : '0;
            checks++;
            if (g !== e) begin
                errs++; $display("FAIL v6_beat got=%h exp=%h", g, e);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        bit tmo, dok, rdy, ctmo;
        int lat, nb, n;
        beat_t e, g;
        for (int i = 0; i < NW; i++) jw[i] = 8'($urandom);
        for (int i = 0; i < VS; i++) jv[i] = 8'($urandom);
        for (int i = 0; i < NR; i++) jx[i] = 8'($urandom);
        load_job(1'b0, 1'b0, tmo);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!valid_out && n < 10) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks += 2;
        if (b_out !== mv[2]) begin
            errs++; $display("FAIL rms_beat2_b got=%h exp=%h", b_out, mv[2]);
        end
        reset = 1'b1;
        #1;
        if (valid_out !== 1'b0) begin
            errs++; $display("FAIL rms_valid got=%b exp=0", valid_out);
        end
        checks += 3;
        if (busy !== 1'b0) begin
            errs++; $display("FAIL rms_busy got=%b exp=0", busy);
        end
        if (in_ready !== 1'b1) begin
            errs++; $display("FAIL rms_ready got=%b exp=1", in_ready);
        end
        if (a_out !== '0) begin
            errs++; $display("FAIL rms_a got=%h exp=0", a_out);
        end
        m_ok = 1'b0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NW; i++) jw[i] = 8'($urandom);
        for (int i = 0; i < VS; i++) jv[i] = 8'($urandom);
        for (int i = 0; i < NR; i++) jx[i] = 8'($urandom);
        load_job(1'b1, 1'b0, tmo);
        collect(1'b0, lat, nb, dok, rdy, ctmo);
        checks += 3;
        if (tmo || ctmo) begin
            errs++; $display("FAIL rms_timeout got=%b/%b exp=0/0", tmo, ctmo);
        end
        if (lat !== 1) begin
            errs++; $display("FAIL rms_latency got=%0d exp=1", lat);
        end
        if (nb !== VS) begin
            errs++; $display("FAIL rms_beats got=%0d exp=%0d", nb, VS);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            checks++;
            if (g !== e) begin
                errs++; $display("FAIL rms_beat got=%h exp=%h", g, e);
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_job();
        test_keep_weights();
        test_keep_after_reset();
        test_toggle();
        test_vec6();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
